dmem_responder: RTL and testbench

- Responder side of the data-memory load/store interface driven by the processor's MEM stage.
- Accepts one request at a time on a valid/ready channel and performs the access against an internal word array.
- Byte-lane placement for stores and sign/zero extension for loads are selected by funct3.
- Returns read data or completion on a separate valid/ready response channel after a configurable number of wait cycles, so the pipelined core can be exercised against stalling memory.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_lane_align.sv | 99 +++++++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int OFF_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr_en;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic             err;
        logic [LANES-1:0] be;
        logic [31:0]      data;
    } st_lane_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } ld_lane_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane placement for stores and extension for loads.
// DMEM_ERR_EN enables misalignment / illegal-funct3 detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic             wr_en,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [31:0]      wdata,
    input  logic [31:0]      raw,
    output logic [LANES-1:0] be,
    output logic [31:0]      wdata_lane,
    output logic [31:0]      rdata,
    output logic             err
);

`ifdef DMEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    function automatic st_lane_t store_lanes(
        input logic [2:0]       f3,
        input logic [OFF_W-1:0] off,
        input logic [31:0]      wd
    );
        st_lane_t s;
        s = '0;
        unique case (1'b1)
            (f3 == F3_SB): begin
                s.be   = 4'b0001 << off;
                s.data = {4{wd[7:0]}};
            end
            (f3 == F3_SH): begin
                s.data = {2{wd[15:0]}};
                s.err  = ERR_EN && off[0];
                if (!s.err)
                    s.be = off[1] ? 4'b1100 : 4'b0011;
            end
            (f3 == F3_SW): begin
                s.data = wd;
                s.err  = ERR_EN && (off != '0);
                if (!s.err)
                    s.be = 4'b1111;
            end
            // Illegal stores never write, flagged only when checking is on.
            default: s.err = ERR_EN;
        endcase
        return s;
    endfunction

    function automatic ld_lane_t load_lanes(
        input logic [31:0]      w,
        input logic [OFF_W-1:0] off,
        input logic [2:0]       f3
    );
        ld_lane_t   l;
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        l = '0;
        unique case (1'b1)
            (f3 == F3_LB):  l.data = {{24{b[7]}}, b};
            (f3 == F3_LBU): l.data = {24'b0, b};
            (f3 == F3_LH): begin
                l.err  = ERR_EN && off[0];
                l.data = {{16{h[15]}}, h};
            end
            (f3 == F3_LHU): begin
                l.err  = ERR_EN && off[0];
                l.data = {16'b0, h};
            end
            (f3 == F3_LW): begin
                l.err  = ERR_EN && (off != '0);
                l.data = w;
            end
            default: begin
                l.err  = ERR_EN;
                l.data = w;
            end
        endcase
        return l;
    endfunction

    st_lane_t st;
    ld_lane_t ld;

    always_comb begin
        st         = store_lanes(funct3, offset, wdata);
        ld         = load_lanes(raw, offset, funct3);
        be         = wr_en ? st.be : '0;
        wdata_lane = st.data;
        err        = wr_en ? st.err : ld.err;
        rdata      = (wr_en || ld.err) ? '0 : ld.data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response with wait states.
// Error detection is built only when DMEM_ERR_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr_en,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int LOGSIZE = $clog2(SIZE);

    state_e             state;
    logic [2:0]         cnt;
    req_t               cap;
    req_t               live;
    req_t               acc;
    logic [WIDTH-1:0]   mem [SIZE];
    logic [LOGSIZE-1:0] idx;
    logic [LANES-1:0]   be;
    logic [31:0]        wdata_lane;
    logic [31:0]        raw;
    logic [31:0]        rdata;
    logic               err;
    logic               enter_resp;
    logic               unused_addr;

    assign live = '{
        addr:   req_addr,
        wr_en:  req_wr_en,
        funct3: req_funct3,
        wdata:  req_wdata
    };

    // With zero wait states the access uses the live request.
    assign acc = (state == IDLE) ? live : cap;

    assign idx         = acc.addr[LOGSIZE+1:2];
    assign unused_addr = ^acc.addr[31:LOGSIZE+2];
    assign raw         = mem[idx];
    assign req_ready   = (state == IDLE) && !rst;

    assign enter_resp = !rst && (
        (state == IDLE && req_valid && LATENCY == 0) ||
        (state == WAIT && cnt == '0));

    dmem_lane_align u_align (
        .wr_en      (acc.wr_en),
        .funct3     (acc.funct3),
        .offset     (acc.addr[OFF_W-1:0]),
        .wdata      (acc.wdata),
        .raw        (raw),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata      (rdata),
        .err        (err)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && acc.wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i])
                    mem[idx][i*LANE_W +: LANE_W] <=
                        wdata_lane[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap <= live;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 3'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= RESP;
                    else
                        cnt <= cnt - 3'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata;
                rsp_err   <= err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=1 and LATENCY=3).
module tb_dmem_responder;

    localparam int LAT = 1;

`ifdef DMEM_ERR_EN
    localparam logic [31:0] LW12_RD = 32'h0;
    localparam logic        ERR_ON  = 1'b1;
    localparam logic [31:0] W_AFTER = 32'h12345678;
`else
    localparam logic [31:0] LW12_RD = 32'h12345678;
    localparam logic        ERR_ON  = 1'b0;
    localparam logic [31:0] W_AFTER = 32'h1234AAAA;
`endif

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        req_valid, req_ready, req_wr_en;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid3, req_ready3, req_wr_en3;
    logic [31:0] req_addr3, req_wdata3;
    logic [2:0]  req_funct3_3;
    logic        rsp_valid3, rsp_ready3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(LAT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wr_en  (req_wr_en),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    dmem_responder #(.LATENCY(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst3),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_addr   (req_addr3),
        .req_wr_en  (req_wr_en3),
        .req_funct3 (req_funct3_3),
        .req_wdata  (req_wdata3),
        .rsp_valid  (rsp_valid3),
        .rsp_ready  (rsp_ready3),
        .rsp_rdata  (rsp_rdata3),
        .rsp_err    (rsp_err3)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Reference model of one access from the architectural rules.
    function automatic void model(
        input  logic [31:0] a,
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] wd,
        input  logic [31:0] w,
        output logic [31:0] rd,
        output logic        er,
        output bit          wr,
        output logic [31:0] nw
    );
        int off, nb;
        bit illegal, sgn;
        logic [31:0] v;
        off = int'(a % 4);
        nb = 1 << f3[1:0];
        illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
        sgn = (f3[2] == 1'b0);
        rd = 0;
        er = 0;
        wr = 0;
        nw = w;
`ifdef DMEM_ERR_EN
        if (illegal || (off % nb) != 0) begin
            er = 1;
            return;
        end
`else
        if (illegal && we) return;
        if (illegal) nb = 4;
        off = off - (off % nb);
`endif
        if (we) begin
            for (int k = 0; k < nb; k++)
                nw[8*(off+k) +: 8] = wd[8*k +: 8];
            wr = 1;
        end else begin
            v = w >> (8 * off);
            if (nb == 1)
                v = (sgn && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
            else if (nb == 2)
                v = (sgn && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
            rd = v;
        end
    endfunction

    logic [31:0] mw [256];
    bit          busy = 0;
    bit          applied;
    bit          p_wr;
    int          due, p_idx;
    logic [31:0] e_rd, p_word;
    logic        e_er, exp_rdy, exp_vld;

    always @(negedge clk) begin
        exp_rdy = !busy && !rst;
        exp_vld = busy && (cyc >= due);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        if (exp_vld) begin
            check("rsp_rdata", rsp_rdata, e_rd);
            check("rsp_err", 32'(rsp_err), 32'(e_er));
            if (!applied && p_wr) mw[p_idx] = p_word;
            applied = 1;
        end
        if (rst) begin
            busy = 0;
        end else if (exp_vld && rsp_ready) begin
            busy = 0;
        end else if (!busy && req_valid) begin
            p_idx = int'((req_addr >> 2) % 256);
            model(req_addr, req_wr_en, req_funct3, req_wdata, mw[p_idx],
                  e_rd, e_er, p_wr, p_word);
            busy = 1;
            applied = 0;
            due = cyc + LAT + 1;
        end
    end

    task automatic xact(input logic [31:0] a, input logic we,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd,
                        output logic er, output int lat);
        int n;
        req_addr = a;
        req_wr_en = we;
        req_funct3 = f3;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!req_ready && n < 40);
        if (!req_ready) timeout("accept");
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end
        while (!rsp_valid && lat < 40);
        if (!rsp_valid) timeout("response");
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic op(input string nm, input logic [31:0] a,
                      input logic we, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold,
                      input logic [31:0] x_rd, input logic x_er);
        logic [31:0] rd;
        logic er;
        int lat;
        xact(a, we, f3, wd, hold, rd, er, lat);
        check({nm, "_rdata"}, rd, x_rd);
        check({nm, "_err"}, 32'(er), 32'(x_er));
        check({nm, "_lat"}, lat, LAT + 1);
    endtask

    task automatic xact3(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output int lat);
        int n;
        req_addr3 = a;
        req_wr_en3 = we;
        req_funct3_3 = 3'b010;
        req_wdata3 = wd;
        req_valid3 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!req_ready3 && n < 40);
        if (!req_ready3) timeout("accept3");
        @(posedge clk); #1 req_valid3 = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end
        while (!rsp_valid3 && lat < 40);
        if (!rsp_valid3) timeout("response3");
        rd = rsp_rdata3;
        @(posedge clk); #1 rsp_ready3 = 1'b1;
        @(posedge clk); #1 rsp_ready3 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd3;
        int lat3;
        rst = 1'b1;
        rst3 = 1'b1;
        req_valid = 0; req_addr = 0; req_wr_en = 0;
        req_funct3 = 0; req_wdata = 0; rsp_ready = 0;
        req_valid3 = 0; req_addr3 = 0; req_wr_en3 = 0;
        req_funct3_3 = 0; req_wdata3 = 0; rsp_ready3 = 0;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst3_rsp_valid", 32'(rsp_valid3), 0);
        @(posedge clk); #1 rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 1);
        check("idle3_req_ready", 32'(req_ready3), 1);
        @(posedge clk); #1;

        op("sw10",  32'h10, 1, 3'b010, 32'hDEADBEEF, 0, 32'h0, 0);
        op("lw10",  32'h10, 0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 0);
        op("lb13",  32'h13, 0, 3'b000, 32'h0, 0, 32'hFFFFFFDE, 0);
        op("lbu13", 32'h13, 0, 3'b100, 32'h0, 0, 32'h000000DE, 0);
        op("lh12",  32'h12, 0, 3'b001, 32'h0, 0, 32'hFFFFDEAD, 0);
        op("lhu10", 32'h10, 0, 3'b101, 32'h0, 0, 32'h0000BEEF, 0);
        op("sb11",  32'h11, 1, 3'b000, 32'h55, 0, 32'h0, 0);
        op("lw10b", 32'h10, 0, 3'b010, 32'h0, 0, 32'hDEAD55EF, 0);
        op("sw410", 32'h410, 1, 3'b010, 32'h12345678, 0, 32'h0, 0);
        op("lw10c", 32'h10, 0, 3'b010, 32'h0, 0, 32'h12345678, 0);

        op("lw12",  32'h12, 0, 3'b010, 32'h0, 0, LW12_RD, ERR_ON);
        op("sh11",  32'h11, 1, 3'b001, 32'hAAAA, 0, 32'h0, ERR_ON);
        op("lw10d", 32'h10, 0, 3'b010, 32'h0, 0, W_AFTER, 0);
        op("st011", 32'h10, 1, 3'b011, 32'hFFFFFFFF, 0, 32'h0, ERR_ON);
        op("ld111", 32'h10, 0, 3'b111, 32'h0, 0,
           ERR_ON ? 32'h0 : W_AFTER, ERR_ON);
        op("hold5", 32'h10, 0, 3'b010, 32'h0, 5, W_AFTER, 0);

        op("sw20",  32'h20, 1, 3'b010, 32'h0, 0, 32'h0, 0);
        op("sh22",  32'h22, 1, 3'b001, 32'hCAFE, 0, 32'h0, 0);
        op("lw20",  32'h20, 0, 3'b010, 32'h0, 0, 32'hCAFE0000, 0);
        op("lh22",  32'h22, 0, 3'b001, 32'h0, 0, 32'hFFFFCAFE, 0);
        op("sb20",  32'h20, 1, 3'b000, 32'h80, 0, 32'h0, 0);
        op("lb20",  32'h20, 0, 3'b000, 32'h0, 0, 32'hFFFFFF80, 0);
        op("lbu20", 32'h20, 0, 3'b100, 32'h0, 0, 32'h00000080, 0);

        op("sw30",  32'h30, 1, 3'b010, 32'hA5A5A5A5, 0, 32'h0, 0);
        req_addr = 32'h30;
        req_wr_en = 1;
        req_funct3 = 3'b010;
        req_wdata = 32'h5A5A5A5A;
        req_valid = 1;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 0; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 0);
        check("post_rst_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        op("lw30",  32'h30, 0, 3'b010, 32'h0, 0, 32'hA5A5A5A5, 0);

        xact3(32'h20, 1, 32'h11111111, rd3, lat3);
        check("l3_sw_lat", lat3, 4);
        check("l3_sw_rdata", rd3, 0);
        req_addr3 = 32'h20;
        req_wr_en3 = 1;
        req_funct3_3 = 3'b010;
        req_wdata3 = 32'h22222222;
        req_valid3 = 1;
        @(negedge clk);
        check("l3_accept", 32'(req_ready3), 1);
        @(posedge clk); #1 req_valid3 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst3 = 1'b1;
        @(negedge clk);
        check("l3_wait_valid", 32'(rsp_valid3), 0);
        check("l3_wait_ready", 32'(req_ready3), 0);
        @(posedge clk); #1 rst3 = 1'b0;
        @(negedge clk);
        check("l3_rst_valid", 32'(rsp_valid3), 0);
        check("l3_rst_ready", 32'(req_ready3), 1);
        @(posedge clk); #1;
        xact3(32'h20, 0, 32'h0, rd3, lat3);
        check("l3_lw_old", rd3, 32'h11111111);
        check("l3_lw_lat", lat3, 4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
